// File: rtl/note_player_pkg.sv
// Shared types and default widths for the note player and its frequency ROM.
package note_player_pkg;

    localparam int NOTE_W_DEFAULT   = 6;
    localparam int DUR_W_DEFAULT    = 6;
    localparam int STEP_W_DEFAULT   = 20;
    localparam int SAMPLE_W_DEFAULT = 16;

    localparam int REST_NOTE = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/note_player_frequency_rom.sv
// Note index to 20-bit phase step for a 48 kHz sine reader (key 49 = A4 = 440 Hz).
// One-cycle registered lookup; entries past the table and the rest note give 0.
module frequency_rom
    import note_player_pkg::*;
#(
    parameter int NOTE_W = NOTE_W_DEFAULT,
    parameter int STEP_W = STEP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NOTE_W-1:0] note,
    output logic [STEP_W-1:0] step
);

    // step = round(440 * 2^((n-49)/12) * 2^20 / 48000)
    localparam logic [19:0] FREQ_TABLE [0:63] = '{
        20'd0,
        20'd601,   20'd636,   20'd674,   20'd714,   20'd757,   20'd802,
        20'd850,   20'd900,   20'd954,   20'd1010,  20'd1070,  20'd1134,
        20'd1201,  20'd1273,  20'd1349,  20'd1429,  20'd1514,  20'd1604,
        20'd1699,  20'd1800,  20'd1907,  20'd2021,  20'd2141,  20'd2268,
        20'd2403,  20'd2546,  20'd2697,  20'd2858,  20'd3028,  20'd3208,
        20'd3398,  20'd3600,  20'd3815,  20'd4041,  20'd4282,  20'd4536,
        20'd4806,  20'd5092,  20'd5395,  20'd5715,  20'd6055,  20'd6415,
        20'd6797,  20'd7201,  20'd7629,  20'd8083,  20'd8563,  20'd9072,
        20'd9612,  20'd10184, 20'd10789, 20'd11431, 20'd12110, 20'd12830,
        20'd13593, 20'd14402, 20'd15258, 20'd16165, 20'd17127, 20'd18145,
        20'd19224, 20'd20367, 20'd21578
    };

    logic [STEP_W-1:0] step_d;
    logic [STEP_W-1:0] step_q;

    always_comb begin
        step_d = '0;
        if (int'(note) < 64) begin
            step_d = STEP_W'(FREQ_TABLE[int'(note)]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/note_player.sv
// Note sequencer: latches note/duration, counts beats, paces the sine reader
// one fetch per codec request and forwards (or mutes) the returned samples.
module note_player
    import note_player_pkg::*;
#(
    parameter int NOTE_W   = NOTE_W_DEFAULT,
    parameter int DUR_W    = DUR_W_DEFAULT,
    parameter int STEP_W   = STEP_W_DEFAULT,
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                play_enable,
    input  logic                load_new_note,
    input  logic [NOTE_W-1:0]   note_to_load,
    input  logic [DUR_W-1:0]    duration_to_load,
    input  logic                beat,
    input  logic                generate_next_sample,
    input  logic                sine_sample_ready,
    input  logic [SAMPLE_W-1:0] sine_sample,
    output logic [STEP_W-1:0]   step_size,
    output logic                sine_generate_next,
    output logic                sine_phase_reset,
    output logic                note_busy,
    output logic                done_with_note,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                new_sample_ready
);

    state_t                state_q,      state_d;
    logic [NOTE_W-1:0]     note_q,       note_d;
    logic [DUR_W-1:0]      dur_q,        dur_d;
    logic                  gen_q,        gen_d;
    logic                  phase_rst_q,  phase_rst_d;
    logic                  done_q,       done_d;
    logic [SAMPLE_W-1:0]   sample_q,     sample_d;
    logic                  valid_q,      valid_d;

    logic active;
    logic expired;
    logic fetch;

    always_comb begin
        state_d     = state_q;
        note_d      = note_q;
        dur_d       = dur_q;
        gen_d       = 1'b0;
        phase_rst_d = 1'b0;
        done_d      = 1'b0;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        fetch       = 1'b0;
        active      = (state_q != IDLE);

        // A load overrides a coincident final beat, so no done pulse then.
        if (load_new_note) begin
            note_d      = note_to_load;
            dur_d       = duration_to_load;
            phase_rst_d = 1'b1;
            done_d      = (duration_to_load == '0);
        end else if (beat && play_enable && active && (dur_q != '0)) begin
            dur_d  = dur_q - DUR_W'(1);
            done_d = (dur_q == DUR_W'(1));
        end

        expired = (dur_d == '0);

        // WAIT never abandons its outstanding fetch; expiry is applied on return.
        unique case (state_q)
            IDLE: begin
                if (load_new_note && !expired) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (expired) begin
                    state_d = IDLE;
                end else if (generate_next_sample && play_enable) begin
                    state_d = WAIT;
                    fetch   = 1'b1;
                end
            end
            WAIT: begin
                if (sine_sample_ready) begin
                    state_d = expired ? IDLE : PLAY;
                end
            end
            default: state_d = IDLE;
        endcase

        gen_d = fetch;

        // Requests that do not fetch are answered at once so the codec never starves.
        if ((state_q == WAIT) && sine_sample_ready) begin
            valid_d  = 1'b1;
            sample_d = (note_q == NOTE_W'(REST_NOTE)) ? '0 : sine_sample;
        end else if (generate_next_sample && (state_q != WAIT) && !fetch) begin
            valid_d = 1'b1;
            if ((state_q == IDLE) || play_enable) begin
                sample_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            note_q      <= '0;
            dur_q       <= '0;
            gen_q       <= 1'b0;
            phase_rst_q <= 1'b0;
            done_q      <= 1'b0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            gen_q       <= gen_d;
            phase_rst_q <= phase_rst_d;
            done_q      <= done_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
        end
    end

    frequency_rom #(
        .NOTE_W (NOTE_W),
        .STEP_W (STEP_W)
    ) u_frequency_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .note    (note_q),
        .step    (step_size)
    );

    assign sine_generate_next = gen_q;
    assign sine_phase_reset   = phase_rst_q;
    assign note_busy          = (state_q != IDLE);
    assign done_with_note     = done_q;
    assign sample_out         = sample_q;
    assign new_sample_ready   = valid_q;

endmodule
